// File: rtl/router_out_arbiter_pkg.sv
// rtl/router_out_arbiter_pkg.sv - shared types and defaults for the router output arbiter
package router_out_arbiter_pkg;

   localparam int N_IN_DEFAULT        = 2;
   localparam int STALL_LIMIT_DEFAULT = 64;

   typedef logic [$clog2(N_IN_DEFAULT)-1:0] grant_idx_t;

   typedef struct packed {
      logic        head;
      logic        tail;
      logic [1:0]  dest;
      logic [11:0] data;
   } pkt_flit_t;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } out_state_t;

endpackage

// File: rtl/router_rr_arbiter.sv
// rtl/router_rr_arbiter.sv - combinational round-robin pick starting at rr_ptr
module router_rr_arbiter #(
   parameter int N_IN = 2
) (
   input  logic [N_IN-1:0]         req,
   input  logic [$clog2(N_IN)-1:0] rr_ptr,
   output logic [N_IN-1:0]         grant_oh,
   output logic [$clog2(N_IN)-1:0] grant_idx,
   output logic                    any_grant
);

   localparam int IW = $clog2(N_IN);

   int idx;

   always_comb begin
      grant_oh  = '0;
      grant_idx = '0;
      any_grant = 1'b0;
      idx       = 0;
      for (int i = 0; i < N_IN; i++) begin
         idx = (int'(rr_ptr) + i) % N_IN;
         if (!any_grant && req[idx]) begin
            grant_oh[idx] = 1'b1;
            grant_idx     = IW'(idx);
            any_grant     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/router_out_arbiter.sv
// rtl/router_out_arbiter.sv - per-output-port reader of the router input FIFOs
// Round-robin pop into a single-entry valid/ready output stage, with counters and stall detection.
module router_out_arbiter
   import router_out_arbiter_pkg::*;
#(
   parameter int N_IN        = 2,
   parameter int CNT_WIDTH   = 16,
   parameter int STALL_LIMIT = STALL_LIMIT_DEFAULT
) (
   input  logic                    clk,
   input  logic                    rst_b,
   input  logic [N_IN-1:0]         fifo_empty,
   input  pkt_flit_t               fifo_out_pkt [N_IN],
   output logic [N_IN-1:0]         fifo_read,
   output pkt_flit_t               out_pkt,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [CNT_WIDTH-1:0]    fwd_count [N_IN],
   output logic [$clog2(N_IN)-1:0] last_grant,
   output logic                    stall_err
);

   localparam int IW = $clog2(N_IN);
   localparam int SW = $clog2(STALL_LIMIT + 1);

   out_state_t      state, state_next;
   logic [IW-1:0]   rr_ptr;
   logic [IW-1:0]   grant_idx;
   logic [N_IN-1:0] req;
   logic [N_IN-1:0] grant_oh;
   logic            any_grant;
   logic            load_en;
   logic            load;
   logic [SW-1:0]   stall_cnt, stall_next;

   assign req     = ~fifo_empty;
   assign load_en = (state == IDLE) || out_ready;
   assign load    = load_en && any_grant;

   router_rr_arbiter #(.N_IN(N_IN)) u_rr (
      .req       (req),
      .rr_ptr    (rr_ptr),
      .grant_oh  (grant_oh),
      .grant_idx (grant_idx),
      .any_grant (any_grant)
   );

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (load)                      state_next = HOLD;
      else if (load_en && out_ready) state_next = IDLE;
   end

   // Gating with rst_b keeps the FIFOs untouched while the whole router is in reset.
   always_comb begin
      out_valid = (state == HOLD);
      fifo_read = '0;
      if (rst_b && load_en) fifo_read = grant_oh;
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         out_pkt    <= '0;
         rr_ptr     <= '0;
         last_grant <= '0;
         for (int i = 0; i < N_IN; i++) fwd_count[i] <= '0;
      end else if (load) begin
         out_pkt              <= fifo_out_pkt[grant_idx];
         rr_ptr               <= IW'((int'(grant_idx) + 1) % N_IN);
         last_grant           <= grant_idx;
         fwd_count[grant_idx] <= fwd_count[grant_idx] + CNT_WIDTH'(1);
      end
   end

   always_comb begin
      stall_next = '0;
      if (out_valid && !out_ready)
         stall_next = (stall_cnt == SW'(STALL_LIMIT)) ? stall_cnt : stall_cnt + SW'(1);
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         stall_cnt <= '0;
         stall_err <= 1'b0;
      end else begin
         stall_cnt <= stall_next;
         stall_err <= stall_err || (stall_next == SW'(STALL_LIMIT));
      end
   end

endmodule

// File: tb/tb_router_out_arbiter.sv
// tb/tb_router_out_arbiter.sv - directed scoreboard bench for router_out_arbiter
module tb_router_out_arbiter;
   import router_out_arbiter_pkg::*;

   localparam int N  = 2;
   localparam int CW = 4;
   localparam int SL = 64;

   logic          clk = 1'b0;
   logic          rst_b;
   logic [N-1:0]  fifo_empty;
   pkt_flit_t     fifo_out_pkt [N];
   logic [N-1:0]  fifo_read;
   pkt_flit_t     out_pkt;
   logic          out_valid;
   logic          out_ready;
   logic [CW-1:0] fwd_count [N];
   logic [0:0]    last_grant;
   logic          stall_err;

   pkt_flit_t q0[$];
   pkt_flit_t q1[$];
   pkt_flit_t exp_q[$];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   router_out_arbiter #(.N_IN(N), .CNT_WIDTH(CW), .STALL_LIMIT(SL)) dut (
      .clk          (clk),
      .rst_b        (rst_b),
      .fifo_empty   (fifo_empty),
      .fifo_out_pkt (fifo_out_pkt),
      .fifo_read    (fifo_read),
      .out_pkt      (out_pkt),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .fwd_count    (fwd_count),
      .last_grant   (last_grant),
      .stall_err    (stall_err)
   );

   function automatic pkt_flit_t mk(input int src, input int n);
      pkt_flit_t p;
      p.head = 1'b1;
      p.tail = 1'b1;
      p.dest = 2'(src);
      p.data = 12'(n);
      return p;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic refresh();
      fifo_empty[0]   = (q0.size() == 0);
      fifo_empty[1]   = (q1.size() == 0);
      fifo_out_pkt[0] = (q0.size() != 0) ? q0[0] : '0;
      fifo_out_pkt[1] = (q1.size() != 0) ? q1[0] : '0;
   endtask

   // One clock: check outgoing transfer against the scoreboard, then pop the FIFOs the DUT read.
   task automatic cycle();
      logic [N-1:0] rd;
      pkt_flit_t    e;
      #1;
      rd = fifo_read;
      chk("read_of_empty", 32'(rd & fifo_empty), 32'd0);
      chk("read_onehot", 32'($countones(rd) <= 1), 32'd1);
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_out", 32'(out_pkt), 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            chk("out_pkt", 32'(out_pkt), 32'(e));
         end
      end
      @(posedge clk);
      #1;
      if (rd[0] && q0.size() != 0) void'(q0.pop_front());
      if (rd[1] && q1.size() != 0) void'(q1.pop_front());
      refresh();
      #1;
   endtask

   task automatic do_reset();
      rst_b     = 1'b0;
      out_ready = 1'b1;
      q0.delete();
      q1.delete();
      exp_q.delete();
      refresh();
      repeat (2) @(posedge clk);
      #1;
      rst_b = 1'b1;
      #1;
   endtask

   initial begin
      // Reset behaviour
      do_reset();
      for (int k = 0; k < 10; k++) begin
         chk("idle_valid", 32'(out_valid), 32'd0);
         chk("idle_read", 32'(fifo_read), 32'd0);
         cycle();
      end
      chk("rst_cnt0", 32'(fwd_count[0]), 32'd0);
      chk("rst_cnt1", 32'(fwd_count[1]), 32'd0);
      chk("rst_last_grant", 32'(last_grant), 32'd0);
      chk("rst_stall_err", 32'(stall_err), 32'd0);
      chk("rst_out_pkt", 32'(out_pkt), 32'd0);

      // Two inputs at full throughput: P0,Q0,P1,Q1
      do_reset();
      q0.push_back(mk(0, 16'h10)); q0.push_back(mk(0, 16'h11));
      q1.push_back(mk(1, 16'h20)); q1.push_back(mk(1, 16'h21));
      exp_q.push_back(mk(0, 16'h10)); exp_q.push_back(mk(1, 16'h20));
      exp_q.push_back(mk(0, 16'h11)); exp_q.push_back(mk(1, 16'h21));
      refresh();
      cycle();
      for (int k = 0; k < 4; k++) begin
         chk("thru_valid", 32'(out_valid), 32'd1);
         cycle();
      end
      chk("thru_drained", 32'(out_valid), 32'd0);
      chk("thru_sb_empty", 32'(exp_q.size()), 32'd0);
      chk("thru_cnt0", 32'(fwd_count[0]), 32'd2);
      chk("thru_cnt1", 32'(fwd_count[1]), 32'd2);

      // Back-pressure and sticky stall error
      do_reset();
      out_ready = 1'b0;
      q0.push_back(mk(0, 16'h30)); q0.push_back(mk(0, 16'h31));
      exp_q.push_back(mk(0, 16'h30)); exp_q.push_back(mk(0, 16'h31));
      refresh();
      cycle();
      for (int k = 1; k < SL; k++) begin
         chk("hold_pkt", 32'(out_pkt), 32'(mk(0, 16'h30)));
         chk("hold_valid", 32'(out_valid), 32'd1);
         chk("hold_read", 32'(fifo_read), 32'd0);
         cycle();
      end
      chk("stall_err_early", 32'(stall_err), 32'd0);
      cycle();
      chk("stall_err_set", 32'(stall_err), 32'd1);
      out_ready = 1'b1;
      cycle();
      cycle();
      chk("stall_sb_empty", 32'(exp_q.size()), 32'd0);
      chk("stall_drained", 32'(out_valid), 32'd0);
      chk("stall_err_sticky", 32'(stall_err), 32'd1);
      chk("stall_cnt0", 32'(fwd_count[0]), 32'd2);

      // Single-input arbitration from input 1
      do_reset();
      for (int k = 0; k < 3; k++) begin
         q1.push_back(mk(1, 16'h40 + k));
         exp_q.push_back(mk(1, 16'h40 + k));
      end
      refresh();
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("single_read", 32'(fifo_read), 32'b10);
         cycle();
      end
      chk("single_last_grant", 32'(last_grant), 32'd1);
      chk("single_rr_ptr", 32'(dut.rr_ptr), 32'd0);
      cycle();
      chk("single_sb_empty", 32'(exp_q.size()), 32'd0);
      chk("single_cnt1", 32'(fwd_count[1]), 32'd3);

      // Reset while holding Q0: packet is discarded, never replayed
      do_reset();
      out_ready = 1'b0;
      q1.push_back(mk(1, 16'h50));
      refresh();
      cycle();
      chk("hold_q0_valid", 32'(out_valid), 32'd1);
      chk("hold_q0_pkt", 32'(out_pkt), 32'(mk(1, 16'h50)));
      #2;
      rst_b = 1'b0;
      #1;
      chk("async_valid_drop", 32'(out_valid), 32'd0);
      q0.push_back(mk(0, 16'h60));
      refresh();
      #1;
      chk("rst_no_read", 32'(fifo_read), 32'd0);
      chk("rst_cnt1_cleared", 32'(fwd_count[1]), 32'd0);
      @(posedge clk);
      #1;
      rst_b     = 1'b1;
      out_ready = 1'b1;
      exp_q.push_back(mk(0, 16'h60));
      #1;
      repeat (3) cycle();
      chk("post_rst_sb_empty", 32'(exp_q.size()), 32'd0);
      chk("post_rst_valid", 32'(out_valid), 32'd0);
      chk("post_rst_cnt0", 32'(fwd_count[0]), 32'd1);

      // Counter wrap with a 4-bit counter
      do_reset();
      for (int k = 0; k < 17; k++) begin
         q0.push_back(mk(0, 16'h100 + k));
         exp_q.push_back(mk(0, 16'h100 + k));
      end
      refresh();
      repeat (18) cycle();
      chk("wrap_sb_empty", 32'(exp_q.size()), 32'd0);
      chk("wrap_cnt0", 32'(fwd_count[0]), 32'd1);
      chk("wrap_valid", 32'(out_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
